// File: rtl/uart_boot_loader_if.sv
// rtl/uart_boot_loader_if.sv - UART RX FIFO pop handshake and instruction-memory write port
//
// Purpose: groups the two buses of the boot loader.
//   rx side  : rx_empty/r_data come from the UART receive FIFO, rd_uart pops it.
//   imem side: imem_we/imem_addr/imem_wdata form a one-cycle word write strobe.
// Modports:
//   master : the boot loader (consumes rx bytes, drives imem writes)
//   slave  : the environment (FIFO + instruction memory)

interface uart_boot_loader_if #(
    parameter int AW = 9
);
    logic          rx_empty;
    logic [7:0]    r_data;
    logic          rd_uart;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    modport master (
        input  rx_empty,
        input  r_data,
        output rd_uart,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output rx_empty,
        output r_data,
        input  rd_uart,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - framed UART image loader that holds the core in reset until a good load
//
// Purpose: pops bytes from the UART RX FIFO, parses
//   SYNC, LEN_LO, LEN_HI, LEN x 4 data bytes (little-endian words), CHK
// and writes each word into instruction memory. The core is released
// (cpu_rst_n=1) only once a frame completes with a matching checksum
// (8-bit sum of the data bytes).
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   bus          uart_boot_loader_if.master: rx_empty/r_data/rd_uart FIFO pop,
//                imem_we/imem_addr/imem_wdata word write (imem_we one cycle per word)
//   cpu_rst_n    core reset, active-low; rises on the edge entering S_DONE
//   done         sticky: image loaded, checksum good
//   err          sticky until next SYNC: length, checksum or inter-byte timeout
//   words_loaded words written by the current or last frame

module uart_boot_loader #(
    parameter int          AW      = 9,
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    uart_boot_loader_if.master bus,
    output logic               cpu_rst_n,
    output logic               done,
    output logic               err,
    output logic [AW:0]        words_loaded
);

    // Counter only ever needs to hold TIMEOUT-1 before firing.
    localparam int            TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [16:0]   MAX_LEN  = 17'(1 << AW);

    typedef enum logic [2:0] {
        S_SYNC,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_SUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state;
    logic          consuming;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          cpu_rst_q;
    logic          done_q;
    logic          err_q;
    logic [AW:0]   wl_q;
    logic [1:0]    idx;
    logic [7:0]    chk;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    len_lo;
    logic [15:0]   len_q;
    logic [23:0]   word_q;

    logic          pop;
    logic          counting;
    logic          tmo_hit;
    logic [15:0]   len_full;
    logic [AW:0]   wl_next;
    logic          last_word;

    // consuming is registered, so the pop strobe is glitch-free apart from
    // the FIFO's own rx_empty, and it is 0 while reset holds consuming low.
    assign pop       = ~bus.rx_empty & consuming;
    assign counting  = (state == S_LEN0) || (state == S_LEN1) ||
                       (state == S_DATA) || (state == S_SUM);
    assign tmo_hit   = counting & bus.rx_empty & (tmo_cnt == TMO_LAST);
    assign len_full  = {bus.r_data, len_lo};
    assign wl_next   = wl_q + (AW+1)'(1);
    assign last_word = (16'(wl_next) == len_q);

    assign bus.rd_uart    = pop;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_rst_n      = cpu_rst_q;
    assign done           = done_q;
    assign err            = err_q;
    assign words_loaded   = wl_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_SYNC;
            consuming <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_rst_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wl_q      <= '0;
            idx       <= '0;
            chk       <= '0;
            tmo_cnt   <= '0;
            len_lo    <= '0;
            len_q     <= '0;
            word_q    <= '0;
        end else begin
            we_q <= 1'b0;

            // Idle counter: any pop or any non-counting state (which covers
            // every state entry that is not itself a pop) restarts it.
            if (pop || !counting) begin
                tmo_cnt <= '0;
            end else if (bus.rx_empty) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            case (state)
                S_SYNC: begin
                    // Also re-arms consuming on the first edge after reset.
                    consuming <= 1'b1;
                    if (pop && bus.r_data == SYNC) begin
                        state  <= S_LEN0;
                        idx    <= '0;
                        chk    <= '0;
                        addr_q <= '0;
                        wl_q   <= '0;
                    end
                end

                S_LEN0: begin
                    if (tmo_hit) begin
                        state     <= S_ERR;
                        err_q     <= 1'b1;
                        cpu_rst_q <= 1'b0;
                    end else if (pop) begin
                        len_lo <= bus.r_data;
                        state  <= S_LEN1;
                    end
                end

                S_LEN1: begin
                    if (tmo_hit) begin
                        state     <= S_ERR;
                        err_q     <= 1'b1;
                        cpu_rst_q <= 1'b0;
                    end else if (pop) begin
                        len_q <= len_full;
                        if (len_full == 16'd0) begin
                            state <= S_SUM;
                        end else if ({1'b0, len_full} > MAX_LEN) begin
                            // Oversized image is rejected before any write.
                            state     <= S_ERR;
                            err_q     <= 1'b1;
                            cpu_rst_q <= 1'b0;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (tmo_hit) begin
                        state     <= S_ERR;
                        err_q     <= 1'b1;
                        cpu_rst_q <= 1'b0;
                    end else if (pop) begin
                        chk <= chk + bus.r_data;
                        idx <= idx + 2'd1;
                        case (idx)
                            2'd0: word_q[7:0]   <= bus.r_data;
                            2'd1: word_q[15:8]  <= bus.r_data;
                            2'd2: word_q[23:16] <= bus.r_data;
                            default: begin
                                // 4th byte goes straight into the write data
                                // so the strobe lands on the very next cycle.
                                wdata_q   <= {bus.r_data, word_q};
                                we_q      <= 1'b1;
                                consuming <= 1'b0;
                                state     <= S_WRITE;
                            end
                        endcase
                    end
                end

                S_WRITE: begin
                    addr_q    <= addr_q + AW'(1);
                    wl_q      <= wl_next;
                    idx       <= '0;
                    consuming <= 1'b1;
                    state     <= last_word ? S_SUM : S_DATA;
                end

                S_SUM: begin
                    if (tmo_hit) begin
                        state     <= S_ERR;
                        err_q     <= 1'b1;
                        cpu_rst_q <= 1'b0;
                    end else if (pop) begin
                        if (bus.r_data == chk) begin
                            state     <= S_DONE;
                            consuming <= 1'b0;
                            done_q    <= 1'b1;
                            cpu_rst_q <= 1'b1;
                        end else begin
                            state     <= S_ERR;
                            err_q     <= 1'b1;
                            cpu_rst_q <= 1'b0;
                        end
                    end
                end

                S_DONE: begin
                    // Terminal until reset; FIFO contents are left for the core.
                    consuming <= 1'b0;
                end

                S_ERR: begin
                    consuming <= 1'b1;
                    cpu_rst_q <= 1'b0;
                    if (pop && bus.r_data == SYNC) begin
                        err_q  <= 1'b0;
                        state  <= S_LEN0;
                        idx    <= '0;
                        chk    <= '0;
                        addr_q <= '0;
                        wl_q   <= '0;
                    end
                end

                default: begin
                    state <= S_SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - directed table-driven bench for uart_boot_loader

module tb_uart_boot_loader;

    localparam int AW = 9;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_rst_n;
    logic        done;
    logic        err;
    logic [AW:0] words_loaded;

    always #5 clk = ~clk;

    uart_boot_loader_if #(.AW(AW)) bus ();

    uart_boot_loader #(
        .AW      (AW),
        .SYNC    (8'hA5),
        .TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.master),
        .cpu_rst_n    (cpu_rst_n),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    typedef struct {
        string        name;
        int           nb;
        logic [191:0] bytes;
        logic         exp_done;
        logic         exp_err;
        logic         exp_rstn;
        int           exp_wl;
        int           exp_writes;
        int           exp_left;
        logic [31:0]  exp_m0;
        logic [31:0]  exp_m1;
    } vec_t;

    logic [7:0]  q[$];
    int          pop_cyc[$];
    int          we_cyc[$];
    logic [31:0] mem[0:3];
    int          n_writes;
    int          cyc;
    int          pass_cnt;
    int          total_cnt;
    vec_t        vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic refresh();
        bus.rx_empty = (q.size() == 0);
        bus.r_data   = (q.size() == 0) ? 8'h00 : q[0];
    endtask

    task automatic clear_stats();
        n_writes = 0;
        pop_cyc.delete();
        we_cyc.delete();
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    endtask

    // One clock: sample strobes mid-cycle, let the edge act, then model the FIFO pop
    // and the memory write that happened on that edge.
    task automatic step();
        logic          p;
        logic          w;
        logic [AW-1:0] a;
        logic [31:0]   d;
        @(negedge clk);
        p = bus.rd_uart;
        w = bus.imem_we;
        a = bus.imem_addr;
        d = bus.imem_wdata;
        @(posedge clk);
        #1;
        cyc++;
        if (p && q.size() > 0) begin
            q.delete(0);
            pop_cyc.push_back(cyc);
        end
        if (w) begin
            n_writes++;
            we_cyc.push_back(cyc);
            if (a < 4) mem[a[1:0]] = d;
        end
        refresh();
    endtask

    task automatic run_until(input int left, input int budget);
        int k;
        k = 0;
        while (q.size() > left && k < budget) begin
            step();
            k++;
        end
        if (q.size() > left) check("fifo_drain_budget", q.size(), left);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        q.delete();
        refresh();
        repeat (2) step();
        reset = 1'b1;
        step();
        clear_stats();
    endtask

    task automatic push_vec(input int nb, input logic [191:0] bytes);
        for (int i = 0; i < nb; i++) q.push_back(bytes[8*(nb-1-i) +: 8]);
        refresh();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        cyc       = 0;
        clear_stats();

        vecs[0] = '{"good", 12, 192'hA5_02_00_78_56_34_12_EF_BE_AD_DE_4C,
                    1'b1, 1'b0, 1'b1, 2, 2, 0, 32'h12345678, 32'hDEADBEEF};
        vecs[1] = '{"bad_chk", 12, 192'hA5_02_00_78_56_34_12_EF_BE_AD_DE_4D,
                    1'b0, 1'b1, 1'b0, 2, 2, 0, 32'h12345678, 32'hDEADBEEF};
        vecs[2] = '{"bad_then_good", 24,
                    192'hA5_02_00_78_56_34_12_EF_BE_AD_DE_4D_A5_02_00_78_56_34_12_EF_BE_AD_DE_4C,
                    1'b1, 1'b0, 1'b1, 2, 4, 0, 32'h12345678, 32'hDEADBEEF};
        vecs[3] = '{"garbage_first", 15, 192'h00_FF_5A_A5_02_00_78_56_34_12_EF_BE_AD_DE_4C,
                    1'b1, 1'b0, 1'b1, 2, 2, 0, 32'h12345678, 32'hDEADBEEF};
        vecs[4] = '{"len_513", 3, 192'hA5_01_02,
                    1'b0, 1'b1, 1'b0, 0, 0, 0, 32'h0, 32'h0};
        vecs[5] = '{"len_zero", 4, 192'hA5_00_00_00,
                    1'b1, 1'b0, 1'b1, 0, 0, 0, 32'h0, 32'h0};
        vecs[6] = '{"trailing_kept", 13, 192'hA5_02_00_78_56_34_12_EF_BE_AD_DE_4C_77,
                    1'b1, 1'b0, 1'b1, 2, 2, 1, 32'h12345678, 32'hDEADBEEF};
        vecs[7] = '{"one_word", 8, 192'hA5_01_00_01_02_03_04_0A,
                    1'b1, 1'b0, 1'b1, 1, 1, 0, 32'h04030201, 32'h0};
        vecs[8] = '{"len_zero_bad", 4, 192'hA5_00_00_01,
                    1'b0, 1'b1, 1'b0, 0, 0, 0, 32'h0, 32'h0};

        // Reset state with a byte waiting in the FIFO: nothing may be popped.
        q.push_back(8'hA5);
        refresh();
        #1;
        check("rst_rd_uart", bus.rd_uart, 0);
        check("rst_imem_we", bus.imem_we, 0);
        check("rst_imem_addr", bus.imem_addr, 0);
        check("rst_imem_wdata", bus.imem_wdata, 0);
        check("rst_cpu_rst_n", cpu_rst_n, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_words", words_loaded, 0);

        for (int v = 0; v < 9; v++) begin
            apply_reset();
            push_vec(vecs[v].nb, vecs[v].bytes);
            run_until(vecs[v].exp_left, 200);
            repeat (3) step();
            check({vecs[v].name, "_done"}, done, vecs[v].exp_done);
            check({vecs[v].name, "_err"}, err, vecs[v].exp_err);
            check({vecs[v].name, "_cpu_rst_n"}, cpu_rst_n, vecs[v].exp_rstn);
            check({vecs[v].name, "_words"}, words_loaded, vecs[v].exp_wl);
            check({vecs[v].name, "_writes"}, n_writes, vecs[v].exp_writes);
            check({vecs[v].name, "_left"}, q.size(), vecs[v].exp_left);
            check({vecs[v].name, "_mem0"}, mem[0], vecs[v].exp_m0);
            check({vecs[v].name, "_mem1"}, mem[1], vecs[v].exp_m1);
        end

        // Inter-byte timeout: err must rise on the 16th idle edge after the last pop.
        apply_reset();
        push_vec(5, 192'hA5_01_00_11_22);
        run_until(0, 50);
        repeat (15) step();
        check("tmo_before_16", err, 0);
        step();
        check("tmo_at_16", err, 1);
        check("tmo_cpu_rst_n", cpu_rst_n, 0);
        check("tmo_writes", n_writes, 0);

        // Reset in the middle of the second word, then a full reload.
        apply_reset();
        push_vec(12, 192'hA5_02_00_78_56_34_12_EF_BE_AD_DE_4C);
        run_until(3, 50);
        check("mid_words_pre", words_loaded, 1);
        reset = 1'b0;
        #1;
        check("mid_rd_uart", bus.rd_uart, 0);
        check("mid_imem_we", bus.imem_we, 0);
        check("mid_imem_addr", bus.imem_addr, 0);
        check("mid_imem_wdata", bus.imem_wdata, 0);
        check("mid_cpu_rst_n", cpu_rst_n, 0);
        check("mid_done", done, 0);
        check("mid_err", err, 0);
        check("mid_words", words_loaded, 0);
        q.delete();
        refresh();
        repeat (2) step();
        reset = 1'b1;
        step();
        clear_stats();
        push_vec(12, 192'hA5_02_00_78_56_34_12_EF_BE_AD_DE_4C);
        run_until(0, 60);
        repeat (3) step();
        check("reload_mem0", mem[0], 32'h12345678);
        check("reload_mem1", mem[1], 32'hDEADBEEF);
        check("reload_done", done, 1);
        check("reload_latency",
              (pop_cyc.size() >= 7 && we_cyc.size() >= 1) ? we_cyc[0] - pop_cyc[6] : -1, 1);
        check("reload_we_spacing",
              (we_cyc.size() >= 2) ? we_cyc[1] - we_cyc[0] : -1, 5);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
